dcache_wb_param: RTL and testbench
==================================

# dcache_wb_param

Parametrised direct-mapped write-back data cache with a registered request/response CPU port and a line-wide memory port driven by a miss FSM. It handles loads and stores: hits complete in fixed latency, and misses evict dirty victims before refilling. Hit and miss statistics are exported. It sits between the core's data-access stage and the shared main-memory controller.

## Interface
- ADDR_W, 16, word-address width.
- DATA_W, 16, word width.
- LINES, 64, number of lines; power of two ≥ 2.
- WORDS, 16, words per line; power of two ≥ 2.
- CNT_W, 16, statistics counter width.
- Derived: IDX_W = log2(LINES), OFF_W = log2(WORDS), TAG_W = ADDR_W − IDX_W − OFF_W (6 with defaults), LINE_W = WORDS·DATA_W.

Ports:
- clk, in, 1, sole clock; all state changes on its rising edge.
- rst_n, in, 1, synchronous active-low reset.
- req_valid, in, 1, CPU request present.
- req_ready, out, 1, cache can accept a request.
- req_we, in, 1, 1 = store, 0 = load.
- req_addr, in, ADDR_W, word address, split as {tag, index, offset}.
- req_wdata, in, DATA_W, store data.
- resp_valid, out, 1, one-cycle completion pulse.
- resp_rdata, out, DATA_W, load data, or the stored word for a store.
- mem_req_valid, out, 1, memory request present.
- mem_req_ready, in, 1, memory accepts the request.
- mem_we, out, 1, 1 = line writeback, 0 = line fill.
- mem_addr, out, ADDR_W−OFF_W, line address {tag, index}.
- mem_wdata, out, LINE_W, victim line; word i occupies bits [DATA_W·(i+1)−1 : DATA_W·i].
- mem_rvalid, in, 1, fill data present.
- mem_rdata, in, LINE_W, fill line, same packing as mem_wdata.
- hit_cnt, out, CNT_W, saturating hit count.
- miss_cnt, out, CNT_W, saturating miss count.

## Operation
- Storage: per line, a valid bit, a dirty bit, a TAG_W-bit tag and WORDS×DATA_W data.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT.
- IDLE:
  - req_ready = 1.
  - The request is accepted when req_valid && req_ready; req_we, req_addr and req_wdata are registered; next state LOOKUP.
- LOOKUP: hit = valid[idx] && tag[idx] == req tag.
  - On a hit, hit_cnt increments.
  - A load hit registers resp_rdata = word.
  - A store hit writes the word, sets dirty and registers resp_rdata = req_wdata.
  - After a hit: resp_valid = 1; next state IDLE.
  - On a miss, miss_cnt increments.
  - Miss with valid && dirty: next state WRITEBACK. Otherwise: next state FILL_REQ.
- WRITEBACK:
  - Drives mem_req_valid = 1, mem_we = 1, mem_addr = {old tag, idx}, mem_wdata = line.
  - Holds these values until mem_req_ready is sampled 1, then goes to FILL_REQ.
- FILL_REQ:
  - Drives mem_req_valid = 1, mem_we = 0, mem_addr = {req tag, idx}.
  - Holds until mem_req_ready is sampled 1, then goes to FILL_WAIT.
- FILL_WAIT: on mem_rvalid, install mem_rdata, set valid and write the tag.
  - For a store, the req word is merged over the fill word before install, and dirty = 1. For a load, dirty = 0.
  - Register resp_rdata, pulse resp_valid, next state IDLE.
- mem_req_ready outside WRITEBACK and FILL_REQ is ignored. mem_rvalid outside FILL_WAIT is ignored.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (rst_n = 0 at an edge):
  - state = IDLE; every valid and dirty bit = 0.
  - hit_cnt = miss_cnt = 0, resp_valid = 0, resp_rdata = 0, mem_req_valid = 0.
  - req_ready = 0 while rst_n = 0.
  - Data and tag arrays are not cleared.
- Reset mid-operation: the in-flight request is abandoned with no response. mem_req_valid is 0 the cycle after the reset edge, and the memory side must tolerate the dropped transaction.
- Acceptance at edge E:
  - Hit: resp_valid = 1 in the cycle after edge E+1 (two edges after acceptance).
  - req_ready = 1 in that same cycle, so back-to-back requests issue one every 2 cycles.
- Clean miss, with memory ready at first assertion and mem_rvalid the cycle after acceptance: resp_valid appears 4 cycles after acceptance.
- A dirty miss adds ≥ 1 cycle for WRITEBACK.
- req_ready = 0 in every state except IDLE.
- mem_req_valid, mem_we, mem_addr and mem_wdata remain stable while mem_req_valid = 1 and mem_req_ready = 0.

## Test plan
- Reset, then load 0x0410:
  - Expect a miss with mem_addr = 0x041 and mem_we = 0.
  - Return a line with word i = 0xA000 + i.
  - Expect resp_rdata = 0xA000 four cycles after acceptance, miss_cnt = 1.
- Load 0x0413 → hit, resp_rdata = 0xA003 two cycles after acceptance, hit_cnt = 1, no memory activity.
- Store 0x0415 with 0xBEEF → hit, then load 0x0415 → 0xBEEF. No mem_req_valid throughout.
- Load 0x0810 (same index 1, tag 2):
  - Expect a WRITEBACK with mem_addr = 0x041 and mem_wdata word 5 = 0xBEEF, word 0 = 0xA000.
  - Then a FILL_REQ with mem_addr = 0x081; miss_cnt = 2.
- Hold mem_req_ready = 0 for 5 cycles during FILL_REQ:
  - mem_req_valid, mem_addr and mem_we stay constant; req_ready = 0.
  - The response follows release.
- Drop rst_n for 1 cycle in FILL_WAIT:
  - Expect no resp_valid and both counters = 0.
  - A subsequent load of 0x0413 misses.
- With CNT_W = 2, issue 5 hits → hit_cnt holds 3.

Source files
------------

// File: rtl/dcache_wb_param.sv
// Direct-mapped write-back data cache: registered CPU request/response port,
// line-wide memory port sequenced by a miss FSM, saturating hit/miss counters.
module dcache_wb_param #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LINES  = 64,
  parameter int unsigned WORDS  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic                                req_we,
  input  logic [ADDR_W-1:0]                   req_addr,
  input  logic [DATA_W-1:0]                   req_wdata,
  output logic                                resp_valid,
  output logic [DATA_W-1:0]                   resp_rdata,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic                                mem_we,
  output logic [ADDR_W-$clog2(WORDS)-1:0]     mem_addr,
  output logic [WORDS*DATA_W-1:0]             mem_wdata,
  input  logic                                mem_rvalid,
  input  logic [WORDS*DATA_W-1:0]             mem_rdata,
  output logic [CNT_W-1:0]                    hit_cnt,
  output logic [CNT_W-1:0]                    miss_cnt
);

  localparam int unsigned IDX_W   = $clog2(LINES);
  localparam int unsigned OFF_W   = $clog2(WORDS);
  localparam int unsigned TAG_W   = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned MADDR_W = ADDR_W - OFF_W;

  typedef logic [WORDS-1:0][DATA_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL_REQ,
    FILL_WAIT
  } state_e;

  state_e              state_q, state_d;

  logic                req_we_q, req_we_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;

  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic                mem_we_q, mem_we_d;
  logic [MADDR_W-1:0]  mem_addr_q, mem_addr_d;
  line_t               mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;

  // Tag and data arrays are never reset; valid bits gate their contents.
  logic [TAG_W-1:0]    tag_q  [LINES];
  line_t               data_q [LINES];

  logic                arr_we;
  line_t               arr_line;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    req_idx;
  logic [OFF_W-1:0]    req_off;
  logic [TAG_W-1:0]    cur_tag;
  line_t               cur_line;
  line_t               fill_line;
  logic                hit;

  // Split the registered request address and look up the indexed line.
  assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx   = req_addr_q[OFF_W +: IDX_W];
  assign req_off   = req_addr_q[OFF_W-1:0];
  assign cur_tag   = tag_q[req_idx];
  assign cur_line  = data_q[req_idx];
  assign fill_line = mem_rdata;
  assign hit       = valid_q[req_idx] && (cur_tag == req_tag);

  // Next-state, datapath and output decisions for the miss FSM.
  always_comb begin
    state_d         = state_q;
    req_we_d        = req_we_q;
    req_addr_d      = req_addr_q;
    req_wdata_d     = req_wdata_q;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = resp_rdata_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    arr_we          = 1'b0;
    arr_line        = cur_line;
    req_ready_d     = 1'b0;
    mem_req_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_we_d    = req_we;
          req_addr_d  = req_addr;
          req_wdata_d = req_wdata;
          state_d     = LOOKUP;
        end
      end

      LOOKUP: begin
        if (hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          if (req_we_q) begin
            arr_we            = 1'b1;
            arr_line[req_off] = req_wdata_q;
            dirty_d[req_idx]  = 1'b1;
          end
          resp_rdata_d = arr_line[req_off];
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {cur_tag, req_idx};
            mem_wdata_d = cur_line;
            state_d     = WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = {req_tag, req_idx};
            state_d    = FILL_REQ;
          end
        end
      end

      WRITEBACK: begin
        if (mem_req_ready) begin
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_idx};
          state_d    = FILL_REQ;
        end
      end

      FILL_REQ: begin
        if (mem_req_ready) state_d = FILL_WAIT;
      end

      FILL_WAIT: begin
        if (mem_rvalid) begin
          arr_we   = 1'b1;
          arr_line = fill_line;
          if (req_we_q) arr_line[req_off] = req_wdata_q;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = req_we_q;
          resp_rdata_d     = arr_line[req_off];
          resp_valid_d     = 1'b1;
          state_d          = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Handshake outputs follow the state being entered so they are registered.
    req_ready_d     = (state_d == IDLE);
    mem_req_valid_d = (state_d == WRITEBACK) || (state_d == FILL_REQ);
  end

  // Control, status and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      req_we_q        <= 1'b0;
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
      valid_q         <= '0;
      dirty_q         <= '0;
    end else begin
      state_q         <= state_d;
      req_we_q        <= req_we_d;
      req_addr_q      <= req_addr_d;
      req_wdata_q     <= req_wdata_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
    end
  end

  // Tag/data array write port; a reset edge abandons any pending install.
  always_ff @(posedge clk) begin
    if (rst_n && arr_we) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= arr_line;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule

// File: tb/tb_dcache_wb_param.sv
// Directed bench for dcache_wb_param: hits, clean/dirty misses, memory stall,
// reset during fill and counter saturation on a narrow-counter twin.
module tb_dcache_wb_param;

  localparam int unsigned AW  = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned WN  = 16;
  localparam int unsigned LW  = WN * DW;
  localparam int unsigned MAW = 12;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic           req_we;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  req_wdata;
  logic           resp_valid;
  logic [DW-1:0]  resp_rdata;
  logic           mem_req_valid;
  logic           mem_req_ready;
  logic           mem_we;
  logic [MAW-1:0] mem_addr;
  logic [LW-1:0]  mem_wdata;
  logic           mem_rvalid;
  logic [LW-1:0]  mem_rdata;
  logic [15:0]    hit_cnt;
  logic [15:0]    miss_cnt;

  logic           s_req_ready;
  logic           s_resp_valid;
  logic [DW-1:0]  s_resp_rdata;
  logic           s_mem_req_valid;
  logic           s_mem_we;
  logic [MAW-1:0] s_mem_addr;
  logic [LW-1:0]  s_mem_wdata;
  logic [1:0]     s_hit_cnt;
  logic [1:0]     s_miss_cnt;

  int             vecs = 0;
  int             errs = 0;

  int             memv_cycles = 0;
  int             wb_cnt = 0;
  int             fill_cnt = 0;
  logic [MAW-1:0] wb_addr = '0;
  logic [MAW-1:0] fill_addr = '0;
  logic           auto_fill = 1'b1;
  logic           fill_pend = 1'b0;
  logic [LW-1:0]  fill_line = '0;

  always #5 clk = ~clk;

  dcache_wb_param dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  dcache_wb_param #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(s_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata),
    .mem_req_valid(s_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  assign mem_rvalid = fill_pend;
  assign mem_rdata  = fill_line;

  // Memory responder (fill data one cycle after fill handshake) and traffic monitor.
  always @(posedge clk) begin
    fill_pend <= auto_fill && mem_req_valid && mem_req_ready && !mem_we;
    if (mem_req_valid) memv_cycles <= memv_cycles + 1;
    if (mem_req_valid && mem_req_ready) begin
      if (mem_we) begin
        wb_cnt  <= wb_cnt + 1;
        wb_addr <= mem_addr;
      end else begin
        fill_cnt  <= fill_cnt + 1;
        fill_addr <= mem_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fill(input logic [DW-1:0] base);
    for (int i = 0; i < int'(WN); i++) fill_line[i*DW +: DW] = base + DW'(i);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_before_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic wait_resp(input string tag, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!resp_valid && k < 40);
    chk(tag, 32'(resp_valid), 32'd1);
  endtask

  task automatic req_chk(input string tag, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int exp_lat, input logic [DW-1:0] exp_data);
    int k;
    issue(we, a, d);
    wait_resp({tag, "_resp"}, k);
    chk({tag, "_lat"}, 32'(k + 1), 32'(exp_lat));
    chk({tag, "_rdata"}, 32'(resp_rdata), 32'(exp_data));
  endtask

  initial begin
    int memv_snap;
    int k;
    int seen;

    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    mem_req_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Clean miss on 0x0410: fill from line 0x041
    set_fill(16'hA000);
    req_chk("miss0410", 1'b0, 16'h0410, 16'h0, 4, 16'hA000);
    chk("miss0410_miss_cnt", 32'(miss_cnt), 32'd1);
    chk("miss0410_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("miss0410_fill_cnt", 32'(fill_cnt), 32'd1);
    chk("miss0410_fill_addr", 32'(fill_addr), 32'h041);
    chk("miss0410_wb_cnt", 32'(wb_cnt), 32'd0);
    chk("miss0410_req_ready", 32'(req_ready), 32'd1);

    // Hits: load, store, load-back, no memory traffic
    memv_snap = memv_cycles;
    req_chk("hit0413", 1'b0, 16'h0413, 16'h0, 2, 16'hA003);
    chk("hit0413_hit_cnt", 32'(hit_cnt), 32'd1);
    req_chk("st0415", 1'b1, 16'h0415, 16'hBEEF, 2, 16'hBEEF);
    req_chk("ld0415", 1'b0, 16'h0415, 16'h0, 2, 16'hBEEF);
    chk("hits_hit_cnt", 32'(hit_cnt), 32'd3);
    chk("hits_no_mem", 32'(memv_cycles), 32'(memv_snap));

    // Dirty miss on 0x0810: writeback of line 0x041, then stalled fill of 0x081
    set_fill(16'hC000);
    issue(1'b0, 16'h0810, 16'h0);
    tick();
    chk("wb_valid", 32'(mem_req_valid), 32'd1);
    chk("wb_we", 32'(mem_we), 32'd1);
    chk("wb_addr", 32'(mem_addr), 32'h041);
    chk("wb_word5", 32'(mem_wdata[5*DW +: DW]), 32'hBEEF);
    chk("wb_word0", 32'(mem_wdata[0 +: DW]), 32'hA000);
    chk("wb_word3", 32'(mem_wdata[3*DW +: DW]), 32'hA003);
    chk("wb_miss_cnt", 32'(miss_cnt), 32'd2);
    chk("wb_req_ready", 32'(req_ready), 32'd0);
    tick();
    mem_req_ready = 1'b0;
    chk("wb_done_cnt", 32'(wb_cnt), 32'd1);
    chk("wb_done_addr", 32'(wb_addr), 32'h041);
    chk("freq_valid", 32'(mem_req_valid), 32'd1);
    chk("freq_we", 32'(mem_we), 32'd0);
    chk("freq_addr", 32'(mem_addr), 32'h081);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(mem_req_valid), 32'd1);
      chk("stall_we", 32'(mem_we), 32'd0);
      chk("stall_addr", 32'(mem_addr), 32'h081);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_resp_valid", 32'(resp_valid), 32'd0);
    end
    mem_req_ready = 1'b1;
    wait_resp("release_resp", k);
    chk("release_lat", 32'(k), 32'd2);
    chk("release_rdata", 32'(resp_rdata), 32'hC000);
    chk("release_fill_addr", 32'(fill_addr), 32'h081);
    chk("release_fill_cnt", 32'(fill_cnt), 32'd2);
    req_chk("hit0813", 1'b0, 16'h0813, 16'h0, 2, 16'hC003);

    // Reset while waiting for fill data: no response, counters cleared
    auto_fill = 1'b0;
    issue(1'b0, 16'h0413, 16'h0);
    tick();
    chk("rstfill_freq", 32'(mem_req_valid), 32'd1);
    tick();
    chk("rstfill_wait", 32'(mem_req_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstfill_resp_valid", 32'(resp_valid), 32'd0);
    chk("rstfill_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("rstfill_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rstfill_miss_cnt", 32'(miss_cnt), 32'd0);
    chk("rstfill_sat_hit_cnt", 32'(s_hit_cnt), 32'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_valid) seen++;
    end
    chk("rstfill_no_resp", 32'(seen), 32'd0);
    auto_fill = 1'b1;
    set_fill(16'hD000);
    req_chk("post_rst0413", 1'b0, 16'h0413, 16'h0, 4, 16'hD003);
    chk("post_rst_miss_cnt", 32'(miss_cnt), 32'd1);

    // Five hits: wide counter reaches 5, 2-bit counter saturates at 3
    memv_snap = memv_cycles;
    for (int i = 0; i < 5; i++)
      req_chk("sat_hit", 1'b0, 16'h0410 + AW'(i), 16'h0, 2, 16'hD000 + DW'(i));
    chk("sat_wide_hit_cnt", 32'(hit_cnt), 32'd5);
    chk("sat_narrow_hit_cnt", 32'(s_hit_cnt), 32'd3);
    chk("sat_narrow_miss_cnt", 32'(s_miss_cnt), 32'd1);
    chk("sat_no_mem", 32'(memv_cycles), 32'(memv_snap));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
